// File: rtl/shift_reg_seq.sv
// shift_reg_seq: sequencer for one systolic-array shift_reg operand buffer.
// It turns a valid/ready word stream into WRITE commands and publishes each
// LENGTH-word frame with UPLOAD. It also runs a non-destructive READ
// readback of the buffer onto an unthrottled output stream.
//
// Ports:
//   clk, reset_n        clock (rising edge), async active-low reset
//   s_valid/s_data      input word stream; s_ready accepts
//   rd_req              readback request (level-sampled)
//   rd_busy             readback in progress
//   m_valid/m_data      readback word stream (m_data wired from sr_data_read)
//   frame_valid         shift_reg.data_out holds a complete frame
//   frame_done          one-cycle pulse when frame_valid rises
//   sr_en, sr_data_read shift_reg.en / shift_reg.data_read
//   sr_ctrl_code        registered command: UPLOAD=0, LOAD=1, WRITE=2, READ=3
//   sr_data_write       registered shift_reg.data_write
module shift_reg_seq #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LENGTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  rd_req,
  output logic                  rd_busy,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  frame_valid,
  output logic                  frame_done,
  input  logic                  sr_en,
  input  logic [DATA_WIDTH-1:0] sr_data_read,
  output logic [1:0]            sr_ctrl_code,
  output logic [DATA_WIDTH-1:0] sr_data_write
);

  localparam int unsigned CNT_W = $clog2(LENGTH + 1);
  localparam int unsigned RD_W  = $clog2(LENGTH);

  localparam logic [1:0] ST_FILL    = 2'd0;
  localparam logic [1:0] ST_PUBLISH = 2'd1;
  localparam logic [1:0] ST_READ    = 2'd2;

  // LOAD (1) is never issued by this block.
  localparam logic [1:0] CODE_UPLOAD = 2'd0;
  localparam logic [1:0] CODE_WRITE  = 2'd2;
  localparam logic [1:0] CODE_READ   = 2'd3;

  logic [1:0]            r_state,       w_state_nxt;
  logic [CNT_W-1:0]      r_cnt,         w_cnt_nxt;
  logic [RD_W-1:0]       r_rd_idx,      w_rd_idx_nxt;
  logic                  r_pub_ph,      w_pub_ph_nxt;
  logic [1:0]            r_code,        w_code_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,       w_wdata_nxt;
  logic                  r_frame_valid, w_frame_valid_nxt;
  logic                  r_frame_done,  w_frame_done_nxt;
  logic                  r_rd_busy,     w_rd_busy_nxt;
  logic                  r_m_valid,     w_m_valid_nxt;
  logic                  w_rd_start;
  logic                  w_accept;

  // Readback may only start on a frame boundary; it takes priority over a word.
  assign w_rd_start = (r_state == ST_FILL) && sr_en && rd_req && (r_cnt == '0);
  // s_ready drops while a readback start wins so the handshake never lies.
  assign s_ready    = (r_state == ST_FILL) && sr_en && !w_rd_start;
  assign w_accept   = s_ready && s_valid;

  assign sr_ctrl_code  = r_code;
  assign sr_data_write = r_wdata;
  assign frame_valid   = r_frame_valid;
  assign frame_done    = r_frame_done;
  assign rd_busy       = r_rd_busy;
  assign m_valid       = r_m_valid;
  assign m_data        = sr_data_read;

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_rd_idx_nxt      = r_rd_idx;
    w_pub_ph_nxt      = r_pub_ph;
    w_code_nxt        = CODE_UPLOAD;
    w_wdata_nxt       = r_wdata;
    w_frame_valid_nxt = r_frame_valid;
    w_frame_done_nxt  = 1'b0;
    w_rd_busy_nxt     = r_rd_busy;
    // shift_reg presents a READ result one cycle after the command.
    w_m_valid_nxt     = (r_code == CODE_READ);

    case (r_state)
      ST_FILL: begin
        if (w_rd_start) begin
          w_state_nxt   = ST_READ;
          w_rd_idx_nxt  = '0;
          w_code_nxt    = CODE_READ;
          w_rd_busy_nxt = 1'b1;
        end else if (w_accept) begin
          w_code_nxt  = CODE_WRITE;
          w_wdata_nxt = s_data;
          if (r_cnt == '0) begin
            w_frame_valid_nxt = 1'b0;
          end
          if (r_cnt == CNT_W'(LENGTH - 1)) begin
            w_cnt_nxt    = '0;
            w_state_nxt  = ST_PUBLISH;
            w_pub_ph_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      // Phase 0 carries the last WRITE and issues UPLOAD; phase 1 carries UPLOAD.
      ST_PUBLISH: begin
        if (!r_pub_ph) begin
          w_pub_ph_nxt = 1'b1;
        end else begin
          w_pub_ph_nxt      = 1'b0;
          w_state_nxt       = ST_FILL;
          w_frame_valid_nxt = 1'b1;
          w_frame_done_nxt  = 1'b1;
        end
      end
      // LENGTH reads rotate the buffer a full turn back to its original order.
      ST_READ: begin
        if (r_rd_idx == RD_W'(LENGTH - 1)) begin
          w_state_nxt   = ST_FILL;
          w_rd_busy_nxt = 1'b0;
        end else begin
          w_rd_idx_nxt = r_rd_idx + RD_W'(1);
          w_code_nxt   = CODE_READ;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_FILL;
      r_cnt         <= '0;
      r_rd_idx      <= '0;
      r_pub_ph      <= 1'b0;
      r_code        <= CODE_UPLOAD;
      r_wdata       <= '0;
      r_frame_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_rd_busy     <= 1'b0;
      r_m_valid     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_rd_idx      <= w_rd_idx_nxt;
      r_pub_ph      <= w_pub_ph_nxt;
      r_code        <= w_code_nxt;
      r_wdata       <= w_wdata_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_rd_busy     <= w_rd_busy_nxt;
      r_m_valid     <= w_m_valid_nxt;
    end
  end

endmodule

// File: tb/tb_shift_reg_seq.sv
// tb_shift_reg_seq: scoreboard bench for shift_reg_seq with a behavioural
// shift_reg model driving sr_data_read and holding data_out.
module tb_shift_reg_seq;

  localparam int unsigned DW = 8;
  localparam int unsigned L  = 4;
  localparam logic [1:0] C_UPLOAD = 2'd0;
  localparam logic [1:0] C_WRITE  = 2'd2;
  localparam logic [1:0] C_READ   = 2'd3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          rd_req = 1'b0;
  logic          rd_busy;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          frame_valid;
  logic          frame_done;
  logic          sr_en = 1'b1;
  logic [DW-1:0] sr_data_read;
  logic [1:0]    sr_ctrl_code;
  logic [DW-1:0] sr_data_write;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fd_prev = 0;
  int fd_last = 0;
  logic prev_fd = 1'b0;

  logic [DW*L-1:0] exp_frames[$];
  logic [DW-1:0]   exp_rd[$];
  logic [DW*L-1:0] last_frame = '0;

  // shift_reg model: FIFO-ordered buffer, data_out snapshot, data_read port.
  logic [DW-1:0] m_buf [L];
  logic [DW-1:0] m_out [L];

  shift_reg_seq #(.DATA_WIDTH(DW), .LENGTH(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .rd_req(rd_req), .rd_busy(rd_busy),
    .m_valid(m_valid), .m_data(m_data),
    .frame_valid(frame_valid), .frame_done(frame_done),
    .sr_en(sr_en), .sr_data_read(sr_data_read),
    .sr_ctrl_code(sr_ctrl_code), .sr_data_write(sr_data_write)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < L; i++) begin
        m_buf[i] <= '0;
        m_out[i] <= '0;
      end
      sr_data_read <= '0;
    end else if (sr_en) begin
      case (sr_ctrl_code)
        C_WRITE: begin
          for (int i = 0; i < L - 1; i++) m_buf[i] <= m_buf[i+1];
          m_buf[L-1] <= sr_data_write;
        end
        C_READ: begin
          sr_data_read <= m_buf[0];
          for (int i = 0; i < L - 1; i++) m_buf[i] <= m_buf[i+1];
          m_buf[L-1] <= m_buf[0];
        end
        C_UPLOAD: begin
          m_out <= m_buf;
          sr_data_read <= '0;
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW*L-1:0] pack_out();
    logic [DW*L-1:0] p = '0;
    for (int i = 0; i < L; i++) p[(L-1-i)*DW +: DW] = m_out[i];
    return p;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a frame or readback word.
  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_done) begin
        fd_prev = fd_last;
        fd_last = cyc;
        check("frame_done_pulse", 64'(prev_fd), 64'(0));
        check("frame_valid_on_done", 64'(frame_valid), 64'(1));
        if (exp_frames.size() == 0) check("frame_unexpected", 64'(1), 64'(0));
        else check("frame_data", 64'(pack_out()), 64'(exp_frames.pop_front()));
      end
      if (m_valid) begin
        if (exp_rd.size() == 0) check("read_unexpected", 64'(1), 64'(0));
        else check("read_data", 64'(m_data), 64'(exp_rd.pop_front()));
      end
    end
    prev_fd = frame_done;
  end

  task automatic send_word(input logic [DW-1:0] w, output int waited, output logic fv_seen);
    int t = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    waited  = t;
    fv_seen = frame_valid;
    if (!s_ready) check("accept_timeout", 64'(s_ready), 64'(1));
    @(negedge clk);
    check("write_code", 64'(sr_ctrl_code), 64'(C_WRITE));
    check("write_data", 64'(sr_data_write), 64'(w));
  endtask

  task automatic send_frame(input logic [DW*L-1:0] f, input int gap_idx, input int gap_len,
                            input bit tail);
    int wt;
    int n = 0;
    logic fv;
    exp_frames.push_back(f);
    for (int i = 0; i < L; i++) begin
      send_word(f[(L-1-i)*DW +: DW], wt, fv);
      if (i == gap_idx && gap_len > 0 && i < L - 1) begin
        s_valid = 1'b0;
        repeat (gap_len) begin
          @(negedge clk);
          check("gap_frame_valid", 64'(frame_valid), 64'(0));
        end
      end
    end
    last_frame = f;
    if (tail) begin
      s_valid = 1'b0;
      while (!s_ready && n < 10) begin
        n++;
        @(negedge clk);
      end
      check("publish_ready_low", 64'(n), 64'(2));
      check("done_at_ready", 64'(frame_done), 64'(1));
      check("fv_at_ready", 64'(frame_valid), 64'(1));
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) check("idle_timeout", 64'(s_ready), 64'(1));
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_frames.size() != 0 || exp_rd.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_frames", 64'(exp_frames.size()), 64'(0));
    check("drain_reads", 64'(exp_rd.size()), 64'(0));
  endtask

  task automatic push_read();
    for (int i = 0; i < L; i++) exp_rd.push_back(last_frame[(L-1-i)*DW +: DW]);
  endtask

  task automatic do_read();
    int n = 0;
    wait_idle();
    push_read();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    while (rd_busy && n < 20) begin
      check("read_s_ready", 64'(s_ready), 64'(0));
      n++;
      @(negedge clk);
    end
    check("read_busy_len", 64'(n), 64'(L));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW*L-1:0] f;
    logic [DW*L-1:0] f2;
    int wt;
    logic fv;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_code", 64'(sr_ctrl_code), 64'(0));
    check("rst_wdata", 64'(sr_data_write), 64'(0));
    check("rst_fv", 64'(frame_valid), 64'(0));
    check("rst_fd", 64'(frame_done), 64'(0));
    check("rst_mv", 64'(m_valid), 64'(0));
    check("rst_busy", 64'(rd_busy), 64'(0));
    check("rst_ready", 64'(s_ready), 64'(1));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic frame, then same words with a mid-frame stall
    send_frame(32'h11223344, -1, 0, 1'b1);
    wait_drain();
    send_frame(32'h11223344, 1, 3, 1'b1);
    wait_drain();

    // Readback, then a fresh frame
    do_read();
    wait_drain();
    send_frame(32'hA1B2C3D4, -1, 0, 1'b1);
    wait_drain();

    // rd_req with two words buffered is ignored
    f = 32'h01020304;
    exp_frames.push_back(f);
    send_word(8'h01, wt, fv);
    send_word(8'h02, wt, fv);
    s_valid = 1'b0;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("ign_rd_busy", 64'(rd_busy), 64'(0));
    check("ign_rd_code", 64'(sr_ctrl_code), 64'(C_UPLOAD));
    send_word(8'h03, wt, fv);
    send_word(8'h04, wt, fv);
    s_valid = 1'b0;
    last_frame = f;
    wait_drain();

    // rd_req and s_valid together at a frame boundary: readback first
    wait_idle();
    f = 32'hC0C1C2C3;
    push_read();
    exp_frames.push_back(f);
    s_valid = 1'b1;
    s_data  = 8'hC0;
    rd_req  = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("conf_busy", 64'(rd_busy), 64'(1));
    check("conf_code", 64'(sr_ctrl_code), 64'(C_READ));
    send_word(8'hC0, wt, fv);
    check("conf_wait", 64'(wt), 64'(L));
    for (int i = 1; i < L; i++) send_word(f[(L-1-i)*DW +: DW], wt, fv);
    s_valid = 1'b0;
    last_frame = f;
    wait_drain();

    // Back-to-back frames with s_valid held high
    f  = 32'h1A1B1C1D;
    f2 = 32'h555A5B5C;
    exp_frames.push_back(f);
    exp_frames.push_back(f2);
    for (int i = 0; i < L; i++) send_word(f[(L-1-i)*DW +: DW], wt, fv);
    send_word(8'h55, wt, fv);
    check("b2b_wait", 64'(wt), 64'(2));
    check("b2b_fv_before", 64'(fv), 64'(1));
    check("b2b_fv_after", 64'(frame_valid), 64'(0));
    for (int i = 1; i < L; i++) send_word(f2[(L-1-i)*DW +: DW], wt, fv);
    s_valid = 1'b0;
    last_frame = f2;
    wait_drain();
    check("b2b_spacing", 64'(fd_last - fd_prev), 64'(L + 2));

    // sr_en low blocks accepts and readback starts
    wait_idle();
    sr_en   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    rd_req  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("en0_ready", 64'(s_ready), 64'(0));
      check("en0_busy", 64'(rd_busy), 64'(0));
      check("en0_code", 64'(sr_ctrl_code), 64'(C_UPLOAD));
    end
    s_valid = 1'b0;
    rd_req  = 1'b0;
    sr_en   = 1'b1;
    @(negedge clk);
    do_read();
    wait_drain();

    // Randomized frames, stalls and readbacks
    for (int it = 0; it < 16; it++) begin
      int gi;
      int gl;
      bit tl;
      for (int i = 0; i < L; i++) f[i*DW +: DW] = DW'($urandom);
      gi = int'($urandom_range(0, L - 2));
      gl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      tl = 1'($urandom_range(0, 1));
      send_frame(f, gi, gl, tl);
      s_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) do_read();
    end
    wait_drain();

    // Reset in the middle of a readback (k=2)
    wait_idle();
    push_read();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rr_code", 64'(sr_ctrl_code), 64'(0));
    check("rr_wdata", 64'(sr_data_write), 64'(0));
    check("rr_fv", 64'(frame_valid), 64'(0));
    check("rr_fd", 64'(frame_done), 64'(0));
    check("rr_mv", 64'(m_valid), 64'(0));
    check("rr_busy", 64'(rd_busy), 64'(0));
    check("rr_ready", 64'(s_ready), 64'(1));
    exp_rd.delete();
    last_frame = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rr_ready_after", 64'(s_ready), 64'(1));
    send_frame(32'hDEADBEEF, -1, 0, 1'b1);
    do_read();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Upstream sequencer for the systolic array's `shift_reg` operand buffers. It turns a valid/ready word stream into `REG_WRITE` commands and publishes each completed LENGTH-word frame with `REG_UPLOAD`. It also runs a non-destructive `REG_READ` readback of the buffer onto an output stream. One instance drives one `shift_reg` through its `ctrl_code`, `data_write`, `data_read` and `en` pins.

## Interface
- `DATA_WIDTH`, 8: word width; must match the driven `shift_reg`.
- `LENGTH`, 4: words per frame; must be ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset. Clock is `clk`; reset is async active-low.
- `s_valid`  in  1: input word valid.
- `s_data`  in  DATA_WIDTH: input word.
- `s_ready`  out  1: word accepted on an edge where `s_valid & s_ready`.
- `rd_req`  in  1: readback request, level-sampled.
- `rd_busy`  out  1: readback in progress.
- `m_valid`  out  1: readback word valid. There is no backpressure on this stream.
- `m_data`  out  DATA_WIDTH: readback word; wired straight from `sr_data_read`.
- `frame_valid`  out  1: `shift_reg.data_out` holds a complete frame.
- `frame_done`  out  1: one-cycle pulse when `frame_valid` rises.
- `sr_en`  in  1: `shift_reg.en`.
- `sr_data_read`  in  DATA_WIDTH: `shift_reg.data_read`.
- `sr_ctrl_code`  out  2: registered; UPLOAD=0, LOAD=1, WRITE=2, READ=3.
- `sr_data_write`  out  DATA_WIDTH: registered `shift_reg.data_write`.

## Operation
- **States:** FILL, PUBLISH, READ.
- **Counter:** `cnt`, width clog2(LENGTH+1), counts accepted words in the current frame.
- **Idle code:** UPLOAD is the idle code. `sr_ctrl_code` = UPLOAD on every cycle not listed below. LOAD is never issued.
- **FILL:**
  - `s_ready = sr_en`.
  - Each accept registers WRITE and `s_data` onto the `sr_*` outputs for exactly one cycle, and increments `cnt`.
  - The accept that makes `cnt == LENGTH` clears `cnt` and moves to PUBLISH.
- **PUBLISH:** lasts 2 cycles with `s_ready=0`. Cycle 1 carries the last WRITE; cycle 2 carries UPLOAD. Then return to FILL.
- **Readback start:** in FILL with `cnt==0` and `sr_en=1`, `rd_req=1` at an edge wins over `s_valid`. No accept happens on that edge, and the block enters READ.
- **READ:**
  - `s_ready=0`, `rd_busy=1`.
  - `sr_ctrl_code`=READ for exactly LENGTH consecutive cycles, then back to FILL.
  - LENGTH reads rotate the buffer a full turn, so its contents are unchanged.
- **Ignored requests:** `rd_req` is ignored while `cnt≠0`, in PUBLISH, or in READ.
- **frame_valid:**
  - Set together with the `frame_done` pulse, one edge after PUBLISH issues UPLOAD.
  - Cleared on the edge that accepts the first word of the next frame.
  - Not cleared by a readback.
- **sr_en=0:** blocks new accepts and readback starts. An operation already in PUBLISH or READ completes.
- **No overflow:** `cnt` never exceeds LENGTH−1 in FILL.

## Timing
- **Reset values (async):**
  - State FILL, `cnt`=0.
  - `sr_ctrl_code`=0 and `sr_data_write`=0.
  - `frame_valid`=0, `frame_done`=0, `m_valid`=0, `rd_busy`=0.
  - `s_ready` follows `sr_en` (it is 1 once `shift_reg` is out of reset).
- **Reset mid-operation:** a reset in PUBLISH or READ abandons the operation. A partial frame is discarded.
- **Write latency:** accept at edge E gives WRITE during [E,E+1); `shift_reg` absorbs the word at E+1.
- **Frame completion:**
  - The last accept at E is followed by UPLOAD during [E+1,E+2).
  - `shift_reg.data_out` updates at E+2; `frame_valid` and `frame_done` rise at E+2.
  - `s_ready` is 0 during [E,E+2) and returns to `sr_en` at E+2.
- **Frame throughput:** LENGTH+2 cycles per frame with `s_valid` held high.
- **Readback:**
  - `rd_req` sampled at R gives READ during [R+k,R+k+1) for k=0..LENGTH−1.
  - `rd_busy` is high over [R,R+LENGTH).
  - `m_valid` is high over [R+1,R+LENGTH+1), one cycle per word.
  - `m_data` = `sr_data_read` = contents[k] in load order.
  - The UPLOAD at R+LENGTH zeroes `sr_data_read`, and `m_valid` falls together with it.
- **Gaps:** gaps in `s_valid` mid-frame issue UPLOAD. This is harmless because `frame_valid` is already 0.

## Test plan
- **Basic frame:** after reset, stream 0x11,0x22,0x33,0x44 back to back (LENGTH=4). Expect 4 WRITE cycles, then UPLOAD; `data_out`={11,22,33,44} with `frame_valid` and a single `frame_done` pulse 2 cycles after the last accept; `s_ready` low for exactly 2 cycles.
- **Stalled frame:** same words with a 3-cycle `s_valid` gap after word 2. Expect `frame_valid` 0 throughout and an identical final `data_out`.
- **Readback:** after the basic frame, pulse `rd_req`. Expect `m_valid` for 4 cycles carrying 11,22,33,44; `rd_busy` for 4 cycles; `s_ready`=0 during READ. A second frame load afterwards produces the correct new `data_out`.
- **Conflicts:** `rd_req` with `cnt`=2 is ignored. `rd_req`+`s_valid` together at `cnt`=0 gives readback first, and the word is accepted after READ ends.
- **Back-to-back frames:** two frames with `s_valid` held high. Expect `frame_valid` to fall on the accept of 0x55, `frame_done` pulses exactly LENGTH+2 cycles apart, and the second `data_out` correct.
- **Reset in READ:** assert `reset_n`=0 mid-READ (k=2). Expect all outputs at reset values immediately, before the next edge; after release, `s_ready`=1 and `cnt`=0.
